// File: rtl/queue_pkg.sv
// Shared encodings and widths for the frame byte queue.
package queue_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_SYNC = 1'b1
    } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with extra-MSB pointers, occupancy level and a registered read port.
module byte_fifo
    import queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level,
    output logic              wr_accept
);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              rd_fire;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    // A full FIFO still takes a write when the same cycle frees a slot.
    assign rd_fire   = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_fire);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/frame_byte_queue.sv
// Frame hunter and payload queue behind the serial framer.
// Define QUEUE_STATS_EN to build the drop/frame statistics counters.
module frame_byte_queue
    import queue_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int PAYLOAD_LEN = 6
) (
    input  logic              ser_clk,
    input  logic              reset,
    input  logic              clk_div_8,
    input  logic [BYTE_W-1:0] par_out,
    input  logic              decode_AB,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level,
    output logic              in_frame,
    output logic              overflow,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        frame_cnt
);

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

    logic   clk_div_8_q;
    logic   byte_stb;
    state_t state, state_next;
    logic [7:0] cnt, cnt_next;
    logic   wr_req;
    logic   wr_accept;
    logic   drop;

    assign byte_stb = clk_div_8 && !clk_div_8_q;
    assign in_frame = (state == ST_SYNC);
    assign drop     = wr_req && !wr_accept;

    always_ff @(posedge ser_clk) begin
        if (reset) begin
            clk_div_8_q <= 1'b0;
            state       <= ST_HUNT;
            cnt         <= '0;
            overflow    <= 1'b0;
        end else begin
            clk_div_8_q <= clk_div_8;
            state       <= state_next;
            cnt         <= cnt_next;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // A marker inside a frame restarts the payload count; dropped bytes still count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wr_req     = 1'b0;
        if (byte_stb) begin
            case (state)
                ST_HUNT: begin
                    if (decode_AB) begin
                        state_next = ST_SYNC;
                        cnt_next   = '0;
                    end
                end
                ST_SYNC: begin
                    if (decode_AB) begin
                        cnt_next = '0;
                    end else begin
                        wr_req = 1'b1;
                        if (cnt == LAST_IDX) begin
                            state_next = ST_HUNT;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt + 8'd1;
                        end
                    end
                end
                default: state_next = ST_HUNT;
            endcase
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (ser_clk),
        .reset     (reset),
        .wr_en     (wr_req),
        .wr_data   (par_out),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .wr_accept (wr_accept)
    );

`ifdef QUEUE_STATS_EN
    logic frame_done;

    assign frame_done = byte_stb && (state == ST_SYNC) && !decode_AB && (cnt == LAST_IDX);

    always_ff @(posedge ser_clk) begin
        if (reset) begin
            drop_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
`else
    assign drop_cnt  = 8'd0;
    assign frame_cnt = 8'd0;
`endif

endmodule
